// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALT sequencing, redirect priority and an
// optional return-address stack compiled in with `define PC_UNIT_RAS_EN.
module pc_unit #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] PC_INC       = 16'd2,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc,
    output logic [15:0] pc_inc,
    input  logic [15:0] pc_plus_inc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    input  logic        jump,
    input  logic [15:0] jump_target,
    input  logic        call,
    input  logic        ret,
    input  logic        halt,
    output logic        fetch_valid,
    output logic        ras_ovf,
    output logic        ras_unf
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;

`ifdef PC_UNIT_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [15:0]      r_stack [RAS_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             w_push;
    logic             w_pop;
    logic             w_ras_empty;
    logic             w_ras_full;
    logic [15:0]      w_ras_top;

    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));
    assign w_ras_top   = r_stack[r_wr_ptr - PTR_W'(1)];

    // NOTE: the stack array has no reset; the empty count alone makes its contents unreachable.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_stack[r_wr_ptr] <= pc_plus_inc;
        end
    end

    // Circular buffer: a push when full lands on the oldest slot, so only the count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_ras_full) r_ovf   <= 1'b1;
            else            r_count <= r_count + CNT_W'(1);
        end else if (w_pop) begin
            if (w_ras_empty) begin
                r_unf <= 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr - PTR_W'(1);
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

    assign ras_ovf = r_ovf;
    assign ras_unf = r_unf;
`else
    logic w_unused_ras_depth;
    assign w_unused_ras_depth = ^RAS_DEPTH;
    assign ras_ovf = 1'b0;
    assign ras_unf = 1'b0;
`endif

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
`ifdef PC_UNIT_RAS_EN
        w_push       = 1'b0;
        w_pop        = 1'b0;
`endif
        case (r_state)
            BOOT: w_state_next = RUN;
            RUN: begin
                if (halt) begin
                    w_state_next = HALT;
                end else if (ret) begin
`ifdef PC_UNIT_RAS_EN
                    w_pop     = 1'b1;
                    w_pc_next = w_ras_empty ? pc_plus_inc : w_ras_top;
`else
                    w_pc_next = jump_target;
`endif
                end else if (call) begin
`ifdef PC_UNIT_RAS_EN
                    w_push    = 1'b1;
`endif
                    w_pc_next = jump_target;
                end else if (jump) begin
                    w_pc_next = jump_target;
                end else if (branch_taken) begin
                    w_pc_next = branch_target;
                end else if (!stall) begin
                    w_pc_next = pc_plus_inc;
                end
            end
            default: w_state_next = HALT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    assign pc          = r_pc;
    assign pc_inc      = PC_INC;
    assign fetch_valid = (r_state == RUN);

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit; the bench supplies the external adder.
// Expected values follow the build: define PC_UNIT_RAS_EN for both files together.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic [15:0] pc_plus_inc;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic        jump;
    logic [15:0] jump_target;
    logic        call;
    logic        ret;
    logic        halt;
    logic        fetch_valid;
    logic        ras_ovf;
    logic        ras_unf;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    always #5 clk = ~clk;

    assign pc_plus_inc = pc + pc_inc;

    pc_unit dut (
        .clk          (clk),
        .rst          (rst),
        .pc           (pc),
        .pc_inc       (pc_inc),
        .pc_plus_inc  (pc_plus_inc),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .call         (call),
        .ret          (ret),
        .halt         (halt),
        .fetch_valid  (fetch_valid),
        .ras_ovf      (ras_ovf),
        .ras_unf      (ras_unf)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] bt;
        logic        jmp;
        logic [15:0] jt;
        logic        call;
        logic        ret;
        logic        halt;
        logic [15:0] pc;
        logic        fv;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic b, logic [15:0] bt, logic j, logic [15:0] jt,
                                logic c, logic r, logic h,
                                logic [15:0] epc, logic efv, logic eovf, logic eunf);
        vec_t v;
        v.stall = s;  v.br = b;  v.bt = bt;  v.jmp = j;  v.jt = jt;
        v.call = c;   v.ret = r; v.halt = h;
        v.pc = epc;   v.fv = efv; v.ovf = eovf; v.unf = eunf;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic [15:0] epc, input logic efv,
                              input logic eovf, input logic eunf);
        check({name, ".pc"}, pc, epc);
        check({name, ".fv"}, {15'd0, fetch_valid}, {15'd0, efv});
        check({name, ".ovf"}, {15'd0, ras_ovf}, {15'd0, eovf});
        check({name, ".unf"}, {15'd0, ras_unf}, {15'd0, eunf});
    endtask

    task automatic drive(input vec_t v);
        stall = v.stall; branch_taken = v.br; branch_target = v.bt;
        jump = v.jmp; jump_target = v.jt; call = v.call; ret = v.ret; halt = v.halt;
    endtask

    task automatic idle();
        drive(mk(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, 0, 0, 0));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();

        // Main stream starts on the first edge after reset is released.
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0004, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0006, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0010, 0, 0, 0, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0010, 1, 0, 0));
        tbl.push_back(mk(1, 1, 16'h0100, 0, 16'h0000, 0, 0, 0, 16'h0100, 1, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0120, 1, 16'h0300, 0, 0, 0, 16'h0300, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0302, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'h0400, 1, 0, 0, 16'h0400, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0500, 1, 1, 0,
                         RAS ? 16'h0304 : 16'h0500, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0600, 0, 1, 0,
                         RAS ? 16'h0306 : 16'h0600, 1, 0, RAS));
        tbl.push_back(mk(0, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 0, 16'hFFFE, 1, 0, RAS));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, RAS));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0002, 1, 0, RAS));
        tbl.push_back(mk(1, 1, 16'h0050, 1, 16'h0040, 0, 0, 0, 16'h0040, 1, 0, RAS));

        // Two reset cycles: pc at the vector, fetch idle, pc_inc constant throughout.
        step();
        expect_out("rst1", 16'h0000, 0, 0, 0);
        check("rst1.pc_inc", pc_inc, 16'd2);
        step();
        expect_out("rst2", 16'h0000, 0, 0, 0);
        check("rst2.pc_inc", pc_inc, 16'd2);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step();
            expect_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].fv, tbl[i].ovf, tbl[i].unf);
        end

        // Halt beats a simultaneous jump and branch, then holds until reset.
        idle();
        jump = 1'b1; jump_target = 16'h0030;
        step();
        check("halt.pre", pc, 16'h0030);
        halt = 1'b1; jump_target = 16'h0700; branch_taken = 1'b1; branch_target = 16'h0800;
        step();
        expect_out("halt.enter", 16'h0030, 0, 0, RAS);
        halt = 1'b0; call = 1'b1; ret = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out($sformatf("halt.hold%0d", k), 16'h0030, 0, 0, RAS);
        end
        rst = 1'b1;
        step();
        expect_out("halt.rst", 16'h0000, 0, 0, 0);
        rst = 1'b0;
        idle();
        step();
        expect_out("halt.boot", 16'h0000, 1, 0, 0);
        step();
        check("halt.seq", pc, 16'h0002);

        // Reset in the middle of a stalled redirect wins on that edge.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0900;
        rst = 1'b1;
        step();
        expect_out("midrst", 16'h0000, 0, 0, 0);
        rst = 1'b0;
        idle();
        step();
        expect_out("midrst.boot", 16'h0000, 1, 0, 0);

`ifdef PC_UNIT_RAS_EN
        // Single call/return pair.
        idle();
        jump = 1'b1; jump_target = 16'h0020;
        step();
        check("cr.at20", pc, 16'h0020);
        jump = 1'b0; call = 1'b1; jump_target = 16'h0200;
        step();
        check("cr.call", pc, 16'h0200);
        idle();
        step();
        step();
        check("cr.at204", pc, 16'h0204);
        ret = 1'b1;
        step();
        expect_out("cr.ret", 16'h0022, 1, 0, 0);

        // Five nested calls overflow a depth-4 stack; the fifth return underflows.
        idle();
        do_reset();
        step();
        check("nest.start", pc, 16'h0000);
        for (int k = 1; k <= 5; k++) begin
            call = 1'b1; jump_target = 16'(k) << 12;
            step();
            check($sformatf("nest.call%0d", k), pc, 16'(k) << 12);
        end
        check("nest.ovf", {15'd0, ras_ovf}, 16'd1);
        idle();
        ret = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            step();
            expect_out($sformatf("nest.ret%0d", 5 - k), (16'(k) << 12) | 16'h0002, 1, 1, 0);
        end
        step();
        expect_out("nest.ret5", 16'h1004, 1, 1, 1);
        idle();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
